// File: rtl/skeleton_clock_gen.sv
// Clock/reset generator for the processor skeleton.
// Derives NUM_CH divided clocks from the master clock, each with a run-time
// half-period, phase invert and enable. Also sequences the core reset: the
// reset is held for RST_HOLD cycles after release, then dropped synchronously.
// Divide/phase changes are staged in shadow registers. A running channel
// picks them up only on its raw falling toggle, so no runt pulses appear.
module skeleton_clock_gen #(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 8,
  parameter int RST_HOLD = 2,
  parameter int DEF_DIV  = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH*DIV_W-1:0] div_cfg,
  input  logic [NUM_CH-1:0]       phase_cfg,
  input  logic                    cfg_load,
  input  logic [NUM_CH-1:0]       ch_enable,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       clk_en,
  output logic                    sys_reset,
  output logic                    ready
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [DIV_W-1:0]  DEF_DIV_V = DIV_W'(DEF_DIV);

  state_t            state_reg, state_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              sys_reset_reg, ready_reg;
  logic              run_now, run_next;

  // Sequencer next state: RST -> HOLD on the first clean edge, HOLD for RST_HOLD cycles, then RUN forever
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    case (state_reg)
      ST_RST: begin
        state_next    = ST_HOLD;
        hold_cnt_next = '0;
      end
      ST_HOLD: begin
        if (hold_cnt_reg == HOLD_LAST) begin
          state_next = ST_RUN;
        end else begin
          hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RST;
      end
    endcase
  end

  // Sequencer registers; sys_reset/ready are registered from the next state so they never glitch
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_RST;
      hold_cnt_reg  <= '0;
      sys_reset_reg <= 1'b1;
      ready_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hold_cnt_reg  <= hold_cnt_next;
      sys_reset_reg <= (state_next != ST_RUN);
      ready_reg     <= (state_next == ST_RUN);
    end
  end

  assign run_now   = (state_reg == ST_RUN);
  assign run_next  = (state_next == ST_RUN);
  assign sys_reset = sys_reset_reg;
  assign ready     = ready_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [DIV_W-1:0] div_act_reg, div_act_next;
    logic [DIV_W-1:0] div_sh_reg, div_sh_next;
    logic [DIV_W-1:0] cnt_reg, cnt_next;
    logic [DIV_W-1:0] d_eff, term;
    logic             phase_act_reg, phase_act_next;
    logic             phase_sh_reg, phase_sh_next;
    logic             pend_reg, pend_next;
    logic             raw_reg, raw_next;
    logic             out_reg, out_next;
    logic             en_reg, en_next;
    logic             pend_eff, idle, wrap, fall;

    // Channel next state: count, toggle raw on wrap, stage/apply config, derive output and rise pulse
    always_comb begin
      div_act_next   = div_act_reg;
      phase_act_next = phase_act_reg;
      cnt_next       = cnt_reg;
      raw_next       = raw_reg;
      pend_next      = pend_reg;

      // A divide of zero behaves like one
      d_eff = (div_act_reg == '0) ? DIV_W'(1) : div_act_reg;
      term  = d_eff - DIV_W'(1);
      wrap  = (cnt_reg == term);

      // Idle: sequencer not running, or disabled with the high half already finished
      idle = !run_now || (!raw_reg && !ch_enable[gi]);
      fall = run_now && raw_reg && wrap;

      // A load in this very cycle counts as the latest shadow content
      div_sh_next   = cfg_load ? div_cfg[gi*DIV_W +: DIV_W] : div_sh_reg;
      phase_sh_next = cfg_load ? phase_cfg[gi] : phase_sh_reg;
      pend_eff      = cfg_load | pend_reg;

      if (idle) begin
        cnt_next = '0;
        raw_next = 1'b0;
      end else if (wrap) begin
        cnt_next = '0;
        raw_next = ~raw_reg;
      end else begin
        cnt_next = cnt_reg + DIV_W'(1);
      end

      if (pend_eff && (idle || fall)) begin
        div_act_next   = div_sh_next;
        phase_act_next = phase_sh_next;
        pend_next      = 1'b0;
      end else begin
        pend_next      = pend_eff;
      end

      out_next = run_next & (raw_next ^ phase_act_next);
      en_next  = out_next & ~out_reg;
    end

    // Channel registers
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        div_act_reg   <= DEF_DIV_V;
        phase_act_reg <= 1'b0;
        div_sh_reg    <= '0;
        phase_sh_reg  <= 1'b0;
        pend_reg      <= 1'b0;
        cnt_reg       <= '0;
        raw_reg       <= 1'b0;
        out_reg       <= 1'b0;
        en_reg        <= 1'b0;
      end else begin
        div_act_reg   <= div_act_next;
        phase_act_reg <= phase_act_next;
        div_sh_reg    <= div_sh_next;
        phase_sh_reg  <= phase_sh_next;
        pend_reg      <= pend_next;
        cnt_reg       <= cnt_next;
        raw_reg       <= raw_next;
        out_reg       <= out_next;
        en_reg        <= en_next;
      end
    end

    assign clk_out[gi] = out_reg;
    assign clk_en[gi]  = en_reg;
  end

endmodule

// File: tb/tb_skeleton_clock_gen.sv
// Bench for skeleton_clock_gen: directed stimulus, an edge-timestamp model of
// every channel checked on each cycle, and hand-computed literal patterns.
module tb_skeleton_clock_gen;

  localparam int NUM_CH   = 4;
  localparam int DIV_W    = 8;
  localparam int RST_HOLD = 2;
  localparam int DEF_DIV  = 1;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic [NUM_CH*DIV_W-1:0] div_cfg = '0;
  logic [NUM_CH-1:0]       phase_cfg = '0;
  logic                    cfg_load = 1'b0;
  logic [NUM_CH-1:0]       ch_enable = '0;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       clk_en;
  logic                    sys_reset;
  logic                    ready;

  skeleton_clock_gen #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .RST_HOLD(RST_HOLD), .DEF_DIV(DEF_DIV)
  ) dut (
    .clock(clock), .reset(reset), .div_cfg(div_cfg), .phase_cfg(phase_cfg),
    .cfg_load(cfg_load), .ch_enable(ch_enable), .clk_out(clk_out),
    .clk_en(clk_en), .sys_reset(sys_reset), .ready(ready)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: toggle times tracked as absolute edge numbers ----------------
  int              e_cnt = 0;
  int              m_edges;
  bit              m_run;
  bit              m_raw      [NUM_CH];
  bit              m_phase    [NUM_CH];
  bit              m_sh_phase [NUM_CH];
  bit              m_pend     [NUM_CH];
  bit              m_counting [NUM_CH];
  int              m_div      [NUM_CH];
  int              m_sh_div   [NUM_CH];
  int              m_next     [NUM_CH];
  logic [NUM_CH-1:0] m_out, m_en;

  function automatic int eff_d(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    m_edges = 0;
    m_run   = 0;
    m_out   = '0;
    m_en    = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_raw[ch] = 0; m_phase[ch] = 0; m_sh_phase[ch] = 0; m_pend[ch] = 0;
      m_counting[ch] = 0; m_div[ch] = DEF_DIV; m_sh_div[ch] = 0; m_next[ch] = 0;
    end
  endtask

  task automatic model_step();
    bit run_before;
    bit pend;
    logic [NUM_CH-1:0] new_out;
    e_cnt++;
    run_before = m_run;
    m_edges++;
    m_run = (m_edges >= RST_HOLD + 1);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      pend = m_pend[ch] || cfg_load;
      if (cfg_load) begin
        m_sh_div[ch]   = int'(div_cfg[ch*DIV_W +: DIV_W]);
        m_sh_phase[ch] = phase_cfg[ch];
      end
      if (!run_before || (!m_raw[ch] && !ch_enable[ch])) begin
        m_raw[ch] = 0;
        m_counting[ch] = 0;
        if (pend) begin m_div[ch] = m_sh_div[ch]; m_phase[ch] = m_sh_phase[ch]; end
        pend = 0;
      end else begin
        if (!m_counting[ch]) begin
          m_counting[ch] = 1;
          m_next[ch] = e_cnt + eff_d(m_div[ch]) - 1;
        end
        if (e_cnt == m_next[ch]) begin
          m_raw[ch] = !m_raw[ch];
          if (!m_raw[ch] && pend) begin
            m_div[ch] = m_sh_div[ch]; m_phase[ch] = m_sh_phase[ch]; pend = 0;
          end
          m_next[ch] = e_cnt + eff_d(m_div[ch]);
        end
      end
      m_pend[ch] = pend;
      new_out[ch] = m_run && (m_raw[ch] ^ m_phase[ch]);
    end
    m_en  = new_out & ~m_out;
    m_out = new_out;
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  // ---------------- per-cycle compare against the model ----------------
  bit cmp_on = 0;
  always @(negedge clock) begin
    if (cmp_on) begin
      check("model_clk_out",   32'(clk_out),   32'(m_out));
      check("model_clk_en",    32'(clk_en),    32'(m_en));
      check("model_sys_reset", 32'(sys_reset), 32'(!m_run));
      check("model_ready",     32'(ready),     32'(m_run));
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [NUM_CH*DIV_W-1:0] mk_div(input int d3, input int d2, input int d1, input int d0);
    return {DIV_W'(d3), DIV_W'(d2), DIV_W'(d1), DIV_W'(d0)};
  endfunction

  task automatic wait_rise(input int ch, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (clk_out[ch] && clk_en[ch]) begin
        ok = 1;
        break;
      end
      step();
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // Released reset: sys_reset high for two samples, ready on the third
  task automatic reseq_check(input string tag);
    step();
    check({tag, "_sysrst1"}, 32'(sys_reset), 32'd1);
    check({tag, "_ready1"},  32'(ready),     32'd0);
    check({tag, "_out1"},    32'(clk_out),   32'd0);
    step();
    check({tag, "_sysrst2"}, 32'(sys_reset), 32'd1);
    check({tag, "_ready2"},  32'(ready),     32'd0);
    step();
    check({tag, "_sysrst3"}, 32'(sys_reset), 32'd0);
    check({tag, "_ready3"},  32'(ready),     32'd1);
  endtask

  logic [NUM_CH-1:0] s_out [12];
  logic [NUM_CH-1:0] s_en  [12];
  logic [9:0]        pat;
  int                cnt_a, cnt_b, cnt_c;

  initial begin
    model_reset();
    @(posedge clock);
    cmp_on = 1;
    @(negedge clock);

    // Test 1: reset held three edges, then release
    check("t1_rst_out",    32'(clk_out),   32'd0);
    check("t1_rst_sysrst", 32'(sys_reset), 32'd1);
    check("t1_rst_ready",  32'(ready),     32'd0);
    step();
    step();
    reset = 1'b1;
    reseq_check("t1");

    // Test 2: all channels at D=1
    ch_enable = 4'hF;
    step();
    check("t2_out_a", 32'(clk_out), 32'hF);
    check("t2_en_a",  32'(clk_en),  32'hF);
    step();
    check("t2_out_b", 32'(clk_out), 32'h0);
    check("t2_en_b",  32'(clk_en),  32'h0);
    step();
    check("t2_out_c", 32'(clk_out), 32'hF);
    check("t2_en_c",  32'(clk_en),  32'hF);
    repeat (5) step();

    // Test 3: mixed dividers, ch2 inverted; configured while idle
    ch_enable = 4'h0;
    repeat (3) step();
    div_cfg   = mk_div(1, 2, 3, 1);
    phase_cfg = 4'b0100;
    cfg_load  = 1'b1;
    step();
    cfg_load  = 1'b0;
    check("t3_idle_inverted", 32'(clk_out), 32'h4);
    step();
    ch_enable = 4'hF;
    for (int k = 0; k < 12; k++) begin
      step();
      s_out[k] = clk_out;
      s_en[k]  = clk_en;
    end
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int k = 0; k < 12; k++) begin
      cnt_a += int'(s_out[k][1]);
      cnt_b += int'(s_en[k][1]);
      cnt_c += int'(s_en[k][2]);
    end
    check("t3_ch1_high_cnt",  32'(cnt_a), 32'd6);
    check("t3_ch1_rise_cnt",  32'(cnt_b), 32'd2);
    check("t3_ch2_rise_cnt",  32'(cnt_c), 32'd3);
    check("t3_ch1_first_rise", 32'(s_en[2][1]), 32'd1);
    check("t3_ch2_first_rise", 32'(s_en[3][2]), 32'd1);

    // Test 4: reload ch1 twice during a high half; last load wins at the falling toggle
    wait_rise(1, "t4_rise_seen");
    pat = '0;
    pat[0] = clk_out[1];
    div_cfg  = mk_div(1, 2, 5, 1);
    cfg_load = 1'b1;
    step();
    pat[1] = clk_out[1];
    div_cfg = mk_div(1, 2, 2, 1);
    step();
    pat[2] = clk_out[1];
    cfg_load = 1'b0;
    for (int k = 3; k < 9; k++) begin
      step();
      pat[k] = clk_out[1];
    end
    check("t4_ch1_pattern", 32'(pat[8:0]), 32'h067);

    // Test 5: ch0 at D=4 (ch3 at D=0), disable mid-high, then re-enable
    div_cfg  = mk_div(0, 2, 2, 4);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    repeat (6) step();
    wait_rise(0, "t5_rise_seen");
    ch_enable[0] = 1'b0;
    pat = '0;
    cnt_a = 0;
    pat[0] = clk_out[0];
    for (int k = 1; k < 10; k++) begin
      step();
      pat[k] = clk_out[0];
      cnt_a += int'(clk_en[0]);
    end
    check("t5_disable_pattern", 32'(pat), 32'h00F);
    check("t5_disable_no_en",   32'(cnt_a), 32'd0);
    ch_enable[0] = 1'b1;
    pat = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      pat[k] = clk_out[0];
      s_en[k] = clk_en;
    end
    check("t5_reenable_pattern", 32'(pat[4:0]), 32'h18);
    check("t5_reenable_en",      32'(s_en[3][0]), 32'd1);

    // Test 6: asynchronous reset mid-run, then resequence
    repeat (2) step();
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_out",    32'(clk_out),   32'd0);
    check("t6_async_en",     32'(clk_en),    32'd0);
    check("t6_async_sysrst", 32'(sys_reset), 32'd1);
    check("t6_async_ready",  32'(ready),     32'd0);
    @(negedge clock);
    step();
    step();
    reset = 1'b1;
    reseq_check("t6");
    step();
    check("t6_first_toggle", 32'(clk_out), 32'hF);
    repeat (6) step();

    cmp_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
